multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control unit that sits directly upstream of the multicycle datapath. It consumes the 6-bit opCode from the instruction register and drives every datapath control line (PCWrite, IorD, ALUSrcB, ...), one instruction at a time.
- All control outputs are Moore-decoded from the current state.
- Provides run/halt gating, a sticky illegal-opcode flag and a retired-instruction counter.
- Memory is synchronous-read, so every memory read spends two states: address, then data.

Parameters:
- HALT_OPCODE, 6'b111111, opcode that parks the FSM in HALT.
- COUNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  when 0, FSM holds in IF1
- opCode  in  6  IR[31:26] from datapath
- PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource, ALUOp, ALUSrcB  out  2 each  datapath controls
- state  out  4  current state code (debug)
- instr_done  out  1  high during final state of an instruction
- illegal  out  1  sticky, unknown opcode decoded
- halted  out  1  state==HALT
- instr_count  out  COUNT_W  retired instructions

Behaviour:
Reset and defaults:
- Async reset sets state=IF1, illegal=0, instr_count=0.
- Outputs after reset are the IF1 decode: MemRead=1 and all other controls 0.
- Every control not listed for a state is 0.

States (code: asserted controls -> next state):
- 0 IF1: MemRead, IorD=0 -> IF2 if run, else IF1. The RAM registers PC at the end of this state.
- 1 IF2: MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 -> DECODE. PC becomes PC+1 and IR loads together.
- 2 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, so ALU register captures the branch target. Next state by opCode:
  - 100011 -> LW_ADR
  - 101011 -> SW
  - 000000 -> R_EX
  - 001000 -> ADDI_EX
  - 000100 -> BEQ
  - 000010 -> JUMP
  - HALT_OPCODE -> HALT
  - anything else -> IF1, set illegal, instr_done=1
- 3 LW_ADR: IorD=1, MemRead, ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> LW_WB.
- 4 LW_WB: same as LW_ADR plus MemtoReg, RegWrite, RegDst=0 -> IF1.
- 5 SW: IorD=1, MemWrite, ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> IF1.
- 6 R_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- 7 R_WB: R_EX controls held, plus RegDst=1, RegWrite, MemtoReg=0 -> IF1. ALU controls are held because write data is taken from the combinational ALU bus.
- 8 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
- 9 ADDI_WB: ADDI_EX controls held, plus RegWrite, RegDst=0 -> IF1.
- 10 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> IF1.
- 11 JUMP: PCWrite, PCSource=10 -> IF1.
- 12 HALT: all controls 0 (MemRead too), halted=1, stays until reset. run is ignored.
- Codes 13-15 are unreachable; if entered, go to IF1 with all controls 0.

Counting and flags:
- instr_done is high in LW_WB, SW, R_WB, ADDI_WB, BEQ, JUMP, and in DECODE for an illegal opcode.
- instr_count increments on each clk edge where instr_done=1 and wraps modulo 2^COUNT_W.
- Cycles per instruction: lw 5, sw 4, R 5, addi 5, beq 4, j 4, illegal 3. HALT takes 3 cycles to enter and does not count.
- illegal stays set until reset.

Run and reset timing:
- run is sampled only in IF1; deasserting run mid-instruction lets that instruction finish.
- Reset mid-instruction aborts it immediately. No write control may stay asserted after reset assertion, since all outputs decode from the reset state.

Test Plan:
- Reset high, run=1 -> state=0, MemRead=1, all other controls 0, instr_count=0. Release reset -> state sequence 0,1,2.
- opCode=100011 -> states 0,1,2,3,4,0. RegWrite and MemtoReg high only in state 4, with IorD=1 in states 3-4. instr_count goes 0->1.
- opCode=000000 then 101011 -> R_WB has RegDst=1, RegWrite=1, ALUOp=10. SW has MemWrite=1 for exactly 1 cycle. instr_count=2 after 9 cycles.
- opCode=000100 -> BEQ shows PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0. opCode=000010 -> JUMP shows PCWrite=1, PCSource=10.
- opCode=010101 -> states 0,1,2,0, illegal=1 and stays 1, instr_count increments. Then run=0 -> FSM holds in state 0 with IRWrite=0.
- opCode=111111 -> state 12, halted=1, all controls 0 for 20 cycles. Async reset pulse mid-cycle -> state=0 immediately, illegal=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath control unit: Moore-decoded control lines, run/halt gating,
// sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opCode,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IF1     = 4'd0,
    S_IF2     = 4'd1,
    S_DECODE  = 4'd2,
    S_LW_ADR  = 4'd3,
    S_LW_WB   = 4'd4,
    S_SW      = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_ADDI_EX = 4'd8,
    S_ADDI_WB = 4'd9,
    S_BEQ     = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   illegal_op;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF1;
    else       state_q <= state_d;
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (illegal_op) illegal <= 1'b1;
      if (instr_done) instr_count <= instr_count + COUNT_W'(1);
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    state_d     = S_IF1;
    illegal_op  = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    instr_done  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IF1: begin
        MemRead = 1'b1;
        state_d = run ? S_IF2 : S_IF1;
      end
      S_IF2: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (opCode == HALT_OPCODE) begin
          state_d = S_HALT;
        end else begin
          case (opCode)
            OP_LW:   state_d = S_LW_ADR;
            OP_SW:   state_d = S_SW;
            OP_R:    state_d = S_R_EX;
            OP_ADDI: state_d = S_ADDI_EX;
            OP_BEQ:  state_d = S_BEQ;
            OP_J:    state_d = S_JUMP;
            default: begin
              state_d    = S_IF1;
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
      end
      S_LW_ADR: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_LW_WB;
      end
      S_LW_WB: begin
        IorD       = 1'b1;
        MemRead    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_SW: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        instr_done = 1'b1;
      end
      S_R_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      // ALU controls stay up: write-back data comes straight off the ALU bus
      S_R_WB: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IF1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an instruction-level
// path/queue model of the control sequence.
module tb_multicycle_control_fsm;

  localparam int unsigned TB_CW = 5;

  logic             clk;
  logic             reset;
  logic             run;
  logic [5:0]       opCode;
  logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic             IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic [3:0]       state;
  logic             instr_done, illegal, halted;
  logic [TB_CW-1:0] instr_count;

  multicycle_control_fsm #(.HALT_OPCODE(6'b111111), .COUNT_W(TB_CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opCode(opCode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .instr_done(instr_done), .illegal(illegal),
    .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current state code plus the queue of states still owed
  int  exp_state;
  int  pend[$];
  bit  exp_illegal;
  int  exp_count;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit op_legal(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000,
                      6'b000100, 6'b000010, 6'b111111};
  endfunction

  // Remaining execution states an opcode owes after DECODE
  task automatic load_path(input logic [5:0] op);
    pend.delete();
    case (op)
      6'b100011: pend = '{3, 4};
      6'b101011: pend = '{5};
      6'b000000: pend = '{6, 7};
      6'b001000: pend = '{8, 9};
      6'b000100: pend = '{10};
      6'b000010: pend = '{11};
      6'b111111: pend = '{12};
      default:   pend.delete();
    endcase
  endtask

  // Expected control vector, written from the per-state control table
  function automatic logic [15:0] exp_ctrl(input int s);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    {pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (s)
      0:  mr = 1;
      1:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
      2:  asb = 2'b11;
      3:  begin iord = 1; mr = 1; asa = 1; asb = 2'b10; end
      4:  begin iord = 1; mr = 1; asa = 1; asb = 2'b10; m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; asa = 1; asb = 2'b10; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin asa = 1; aop = 2'b10; rd = 1; rw = 1; end
      8:  begin asa = 1; asb = 2'b10; end
      9:  begin asa = 1; asb = 2'b10; rw = 1; end
      10: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, aop, asb};
  endfunction

  task automatic model_reset();
    exp_state   = 0;
    pend.delete();
    exp_illegal = 0;
    exp_count   = 0;
  endtask

  task automatic check_outputs();
    logic [15:0] got_ctrl;
    bit exp_done;
    got_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
    exp_done = (exp_state >= 3 && exp_state <= 11 && pend.size() == 0) ||
               (exp_state == 2 && !op_legal(opCode));
    chk_eq("state",       32'(state),       32'(exp_state));
    chk_eq("controls",    32'(got_ctrl),    32'(exp_ctrl(exp_state)));
    chk_eq("instr_done",  32'(instr_done),  32'(exp_done));
    chk_eq("illegal",     32'(illegal),     32'(exp_illegal));
    chk_eq("halted",      32'(halted),      32'(exp_state == 12));
    chk_eq("instr_count", 32'(instr_count), 32'(exp_count));
  endtask

  // Model update for one rising edge, using the inputs held across it
  task automatic advance();
    if (exp_state == 12) begin
      exp_state = 12;
    end else if (exp_state == 0) begin
      exp_state = run ? 1 : 0;
    end else if (exp_state == 1) begin
      exp_state = 2;
    end else begin
      if (exp_state == 2) begin
        load_path(opCode);
        if (!op_legal(opCode)) exp_illegal = 1;
      end
      if (pend.size() == 0) begin
        exp_count = (exp_count + 1) % (1 << TB_CW);
        exp_state = 0;
      end else begin
        exp_state = pend.pop_front();
      end
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    if ($urandom_range(0, 4) == 0) begin
      op = 6'($urandom);
      if (op == 6'b111111) op = 6'b010101;
    end else begin
      op = ops[$urandom_range(0, 5)];
    end
    return op;
  endfunction

  // Run one instruction to retirement from IF1, bounded
  task automatic run_one(input logic [5:0] op);
    int start_count;
    bit done;
    start_count = exp_count;
    done = 0;
    opCode = op;
    run = 1'b1;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      if (exp_count != start_count && exp_state == 0) done = 1;
    end
    chk_eq("retire_bound", 32'(done), 32'd1);
  endtask

  initial begin
    logic [5:0] dir_ops [6];
    dir_ops = '{6'b100011, 6'b000000, 6'b101011, 6'b000100, 6'b000010, 6'b010101};
    reset  = 1'b1;
    run    = 1'b1;
    opCode = 6'b000000;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    foreach (dir_ops[k]) run_one(dir_ops[k]);

    run = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random phase: opcode changes only while fetching, run toggles freely
    for (int i = 0; i < 1500; i++) begin
      if (exp_state == 0) opCode = rand_op();
      run = ($urandom_range(0, 3) != 0);
      step();
    end

    run = 1'b1;
    for (int i = 0; i < 12 && exp_state != 0; i++) step();
    chk_eq("reach_if1", 32'(exp_state), 32'd0);

    opCode = 6'b111111;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom);
      opCode = 6'($urandom);
      step();
    end

    // Asynchronous reset asserted between clock edges
    @(posedge clk);
    advance();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) run_one(rand_op());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
